// File: rtl/rs_bank_pkg.sv
// Shared definitions for the reservation-station banks: opcodes, tag/data widths,
// per-bank base tags and the station entry layout.
package rs_bank_pkg;

  localparam int TAG_W        = 6;
  localparam int DATA_W       = 16;
  localparam int FXU_BASE_TAG = 0;
  localparam int LD_BASE_TAG  = 4;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_ADD = 4'd1,
    OP_JMP = 4'd2,
    OP_HLT = 4'd3,
    OP_LD  = 4'd4,
    OP_LDR = 4'd5,
    OP_JEQ = 4'd6
  } opcode_e;

  // Operand index 0 is source A, index 1 is source B.
  typedef struct packed {
    logic                        issued;
    logic                        busy;
    logic [3:0]                  op;
    logic [1:0]                  rdy;
    logic [1:0][TAG_W-1:0]       src;
    logic [1:0][DATA_W-1:0]      val;
  } rs_entry_t;

endpackage

// File: rtl/rs_bank_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag; idx is 0 when nothing is set.
module prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scanning downwards lets the lowest requesting index be the last to assign.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: takes renamed instructions, snoops the CDB for operands,
// issues the lowest ready entry to its FU and frees an entry on its own tag.
module rs_bank #(
  parameter int ENTRIES  = 4,
  parameter int IDX_W    = 2,
  parameter int TAG_W    = rs_bank_pkg::TAG_W,
  parameter int BASE_TAG = rs_bank_pkg::FXU_BASE_TAG,
  parameter int DATA_W   = rs_bank_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_v,
  input  logic [3:0]        disp_op,
  input  logic              disp_rdy_a,
  input  logic              disp_rdy_b,
  input  logic [TAG_W-1:0]  disp_src_a,
  input  logic [TAG_W-1:0]  disp_src_b,
  input  logic [DATA_W-1:0] disp_val_a,
  input  logic [DATA_W-1:0] disp_val_b,
  output logic              full,
  output logic [TAG_W-1:0]  free_tag,
  input  logic              cdb_v,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              iss_v,
  input  logic              iss_ready,
  output logic [TAG_W-1:0]  iss_tag,
  output logic [3:0]        iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b
);
  import rs_bank_pkg::*;

  rs_entry_t          ent [ENTRIES];
  logic [ENTRIES-1:0] busy_vec;
  logic [ENTRIES-1:0] elig_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   iss_idx;
  logic               free_any;
  logic               byp_a;
  logic               byp_b;

  always_comb begin
    busy_vec = '0;
    elig_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_vec[i] = ent[i].busy;
      elig_vec[i] = ent[i].busy && !ent[i].issued && (&ent[i].rdy);
    end
  end

  prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_free_sel (
    .req   (~busy_vec),
    .idx   (free_idx),
    .valid (free_any)
  );

  prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_iss_sel (
    .req   (elig_vec),
    .idx   (iss_idx),
    .valid (iss_v)
  );

  assign full     = !free_any;
  assign free_tag = TAG_W'(BASE_TAG) + TAG_W'(free_idx);
  assign iss_tag  = TAG_W'(BASE_TAG) + TAG_W'(iss_idx);
  assign iss_op   = ent[iss_idx].op;
  assign iss_a    = ent[iss_idx].val[0];
  assign iss_b    = ent[iss_idx].val[1];

  // An operand still waiting at dispatch can be satisfied by this cycle's broadcast.
  assign byp_a = cdb_v && !disp_rdy_a && (disp_src_a == cdb_tag);
  assign byp_b = cdb_v && !disp_rdy_b && (disp_src_b == cdb_tag);

  // Later assignments override earlier ones, so a completion beats an issue of the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int x = 0; x < 2; x++) begin
          if (cdb_v && ent[i].busy && !ent[i].rdy[x] && (ent[i].src[x] == cdb_tag)) begin
            ent[i].rdy[x] <= 1'b1;
            ent[i].val[x] <= cdb_val;
          end
        end
        if (iss_v && iss_ready && (iss_idx == IDX_W'(i))) begin
          ent[i].issued <= 1'b1;
        end
        if (cdb_v && ent[i].busy && (cdb_tag == TAG_W'(BASE_TAG + i))) begin
          ent[i].busy   <= 1'b0;
          ent[i].issued <= 1'b0;
        end
        if (disp_v && free_any && (free_idx == IDX_W'(i))) begin
          ent[i].busy   <= 1'b1;
          ent[i].issued <= 1'b0;
          ent[i].op     <= disp_op;
          ent[i].src[0] <= disp_src_a;
          ent[i].src[1] <= disp_src_b;
          ent[i].rdy[0] <= disp_rdy_a || byp_a;
          ent[i].rdy[1] <= disp_rdy_b || byp_b;
          ent[i].val[0] <= byp_a ? cdb_val : disp_val_a;
          ent[i].val[1] <= byp_b ? cdb_val : disp_val_b;
        end
      end
    end
  end

  // Completing an entry in the same cycle it is handed to the FU means the result predates the issue.
  no_free_while_issuing: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(iss_v && iss_ready && cdb_v && (cdb_tag == iss_tag))
  );

endmodule
